// File: rtl/shift_pkg.sv
// Shared shifter/normalizer types: FSM state encoding and mode opcodes.
// The mode constants are also used by the combinational shifter's opcode decode.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

endpackage

// File: rtl/norm_detect.sv
// Combinational normalized/zero detection on the working word; no latency, no flow control.
// Sign-aware detection exists only when SHIFT_NORM_ARITH_EN is defined.
module norm_detect
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             is_norm,
  output logic             is_zero
);

`ifdef SHIFT_NORM_ARITH_EN
  always_comb begin
    is_norm = data[WIDTH-1];
    is_zero = (data == '0);
    if (mode == MODE_ARITH) begin
      // Normalized once the bit below the sign differs from it; all-sign words never get there.
      is_norm = data[WIDTH-1] ^ data[WIDTH-2];
      is_zero = (data == '0) || (&data);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    is_norm = data[WIDTH-1];
    is_zero = (data == '0);
  end
`endif

endmodule

// File: rtl/shift_normalizer.sv
// Sequential left-normalizer, one shift per cycle; done n+1 cycles after start (n = shift count).
// No backpressure: start is ignored while busy; arithmetic mode only with SHIFT_NORM_ARITH_EN.
module shift_normalizer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] norm_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic             mode_eff;
  logic             is_norm;
  logic             is_zero;
  logic             accept;

  assign norm_out = data;
  assign accept   = start && (state != SHIFT);

`ifdef SHIFT_NORM_ARITH_EN
  logic mode_q;
  assign mode_eff = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = MODE_LOGIC;
`endif

  norm_detect #(
    .WIDTH (WIDTH)
  ) u_detect (
    .data    (data),
    .mode    (mode_eff),
    .is_norm (is_norm),
    .is_zero (is_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      shift_cnt <= '0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SHIFT_NORM_ARITH_EN
      mode_q    <= MODE_LOGIC;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        SHIFT: begin
          if (is_zero) begin
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (is_norm) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // A nonzero word normalizes within WIDTH-1 shifts, so the count cannot wrap.
            data      <= {data[WIDTH-2:0], 1'b0};
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            data      <= din;
            shift_cnt <= '0;
            zero      <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
`ifdef SHIFT_NORM_ARITH_EN
            mode_q    <= mode;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Randomized scoreboard bench for shift_normalizer against a leading-bit-count reference model.
module tb_shift_normalizer;

  localparam int W  = 4;
  localparam int CW = $clog2(W);
`ifdef SHIFT_NORM_ARITH_EN
  localparam bit ARITH_EN = 1'b1;
`else
  localparam bit ARITH_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [W-1:0]  din   = '0;
  logic [W-1:0]  norm_out;
  logic [CW-1:0] shift_cnt;
  logic          zero;
  logic          busy;
  logic          done;

  shift_normalizer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .din       (din),
    .norm_out  (norm_out),
    .shift_cnt (shift_cnt),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] din;
    logic         arith;
    logic [W-1:0] norm;
    int           cnt;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count leading bits equal to the reference bit, then shift them out.
  function automatic void model(input logic [W-1:0] d, input logic arith,
                                output logic [W-1:0] nrm, output int n, output logic z);
    n = 0;
    z = 1'b0;
    if (!arith) begin
      if (d == '0) z = 1'b1;
      else while (d[W-1-n] == 1'b0) n++;
    end else begin
      if (d == '0 || d == '1) z = 1'b1;
      else while (d[W-2-n] == d[W-1]) n++;
    end
    nrm = d << n;
  endfunction

  task automatic issue(input logic [W-1:0] d, input logic m, input bit expect_done);
    exp_t e;
    start = 1'b1;
    din   = d;
    mode  = m;
    if (expect_done) begin
      e.din   = d;
      e.arith = m && ARITH_EN;
      model(d, e.arith, e.norm, e.cnt, e.zero);
      e.cyc   = cyc + e.cnt + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    din   = W'($urandom);
    mode  = 1'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check("done_seen", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_norm"}, norm_out, 0);
    check({tag, "_cnt"}, shift_cnt, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("norm_out", norm_out, mon_e.norm);
        check("shift_cnt", shift_cnt, mon_e.cnt);
        check("zero", zero, mon_e.zero);
        check("done_cycle", cyc, mon_e.cyc);
        check("busy_at_done", busy, 0);
        if (!mon_e.zero && !mon_e.arith)
          check("recover_din", int'(norm_out >> shift_cnt), mon_e.din);
      end
    end
  end

  logic [W-1:0] dir_din  [6] = '{4'b0011, 4'b1000, 4'b0000, 4'b1110, 4'b0001, 4'b1111};
  logic         dir_mode [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(dir_din[i], dir_mode[i], 1'b1);
      wait_done();
      @(negedge clk);
    end

    // Back-to-back: next start lands in the DONE cycle.
    issue(4'b0011, 1'b0, 1'b1);
    wait_done();
    issue(4'b0001, 1'b0, 1'b1);
    wait_done();
    issue(4'b0100, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    // Start during SHIFT must be dropped.
    issue(4'b0001, 1'b0, 1'b1);
    start = 1'b1;
    din   = 4'b1000;
    @(negedge clk);
    check("busy_mid_shift", busy, 1);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Asynchronous abort mid-SHIFT.
    issue(4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
    end
    issue(4'b0011, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    repeat (150) begin
      issue(W'($urandom), 1'($urandom), 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Sequential normalizer: the inverse of the team's left-shift datapath. Given a word, it shifts left one bit per cycle until the word is normalized and reports how far it moved, so `norm_out >> shift_cnt` (logical) recovers the input. It sits beside the combinational shifter in the non-memory datapath and feeds shift amounts back into it for renormalization.

## Interface
- `WIDTH`, default 4: data width; legal for WIDTH ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: shift-count width; holds a maximum count of WIDTH-1.

Ports:
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse; sampled only when `busy`=0.
- `mode`  in  1: 0 = logical normalize, 1 = arithmetic normalize. Sampled with `start`.
- `din`  in  WIDTH: operand. Sampled with `start`.
- `norm_out`  out  WIDTH: normalized word.
- `shift_cnt`  out  CNT_W: number of left shifts applied.
- `zero`  out  1: the operand has no normalizable content.
- `busy`  out  1: high in SHIFT only.
- `done`  out  1: one-cycle result strobe.

## Operation
- **Reset:** state IDLE. `norm_out`, `shift_cnt`, `zero`, `busy` and `done` are all 0.
- **States:** IDLE, SHIFT, DONE.
- **Start acceptance:** `start` is accepted in IDLE or DONE.
  - On acceptance: load `din` into the working register, clear `shift_cnt` and `zero`, latch `mode`, then go to SHIFT.
  - `start` during SHIFT is ignored; there is no queueing.
- **SHIFT, per cycle:** evaluate the normalized condition on the working register.
  - Logical mode: `data[WIDTH-1]`=1.
  - Arithmetic mode: `data[WIDTH-1]` ≠ `data[WIDTH-2]`.
- **SHIFT, terminal cases:**
  - Logical, all-zero word: set `zero`=1, go to DONE.
  - Arithmetic, all-zeros or all-ones word: set `zero`=1, go to DONE.
  - In both zero cases `norm_out` equals `din` and `shift_cnt`=0.
- **SHIFT, progress:**
  - If the word is normalized, go to DONE.
  - Otherwise shift left by 1 (zero fill) and increment `shift_cnt`.
- **DONE:** `done`=1 for exactly one cycle.
  - Return to IDLE, unless `start` is accepted in the same cycle.
- **Output stability:** results are stable from `done` until the next accepted `start`. During SHIFT they show in-progress values and are not valid.
- **Invariants:**
  - `shift_cnt` ≤ WIDTH-1 and never wraps.
  - In arithmetic mode the sign bit is preserved.
- **Reset mid-operation:** aborts immediately, returns to IDLE, and all outputs go to 0. No `done` is issued for the aborted request.

## Timing
- Let `start` be sampled at edge 0, and let n be the final `shift_cnt`.
- Edges 1..n perform the shifts. The check at edge n+1 moves the state to DONE, so `done` is high between edges n+1 and n+2.
- Latency: n+1 cycles from start to done. Zero operands give n=0, so latency is 1.
- Back-to-back: a `start` accepted in the DONE cycle begins the next operation with no idle gap.
- `busy` rises after edge 0 and falls in the same edge that raises `done`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SHIFT_NORM_ARITH_EN` defined: arithmetic mode (`mode`=1) is implemented as described above.
- Undefined:
  - `mode` is ignored; every request runs logical normalization.
  - The sign-detection logic is not synthesized.
  - Timing is unchanged.

## Structure
- **Shared package** `shift_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - mode constants `MODE_LOGIC`=1'b0 and `MODE_ARITH`=1'b1, reused by the shifter's opcode decode.
- **Sub-module** `norm_detect` (combinational):
  - inputs: working word, mode;
  - outputs: `is_norm` and `is_zero`;
  - the FSM and counter live in `shift_normalizer`.

## Test plan
- Logical, `din`=4'b0011 → `norm_out`=4'b1100, `shift_cnt`=2, `zero`=0, `done` between edges 3 and 4.
- Logical, `din`=4'b1000 → `norm_out`=4'b1000, `shift_cnt`=0, `done` between edges 1 and 2. Logical, `din`=0 → `zero`=1, `shift_cnt`=0, `norm_out`=0.
- Arithmetic (macro on):
  - `din`=4'b1110 → 4'b1000, count 2;
  - `din`=4'b0001 → 4'b0100, count 2;
  - `din`=4'b1111 → `zero`=1, count 0.
- Macro off, `mode`=1, `din`=4'b0001 → `norm_out`=4'b1000, `shift_cnt`=3 (logical behaviour).
- `start` pulsed mid-SHIFT is ignored; `start` in the DONE cycle runs back-to-back. Random logical sweep: `norm_out >> shift_cnt` equals `din` for every nonzero input.
- Deassert `rst_n` during SHIFT of `din`=4'b0001 → immediately all outputs 0 and state IDLE; no `done` is seen; the next `start` completes normally.
